m72_rom_loader: RTL and testbench

- Sits between the host ioctl download stream and the m72 core's ROM memories; it is the stage that consumes ioctl_wr/ioctl_addr/ioctl_dout.
- Parses a fixed region-size header at the start of the index-0 stream.
- Packs the following bytes into 16-bit words and issues one region-tagged write per word over a req/ack handshake.
- Throttles the host with ioctl_wait while a write is outstanding.

---
 rtl/m72_loader_pkg.sv | 24 ++
 rtl/m72_region_map.sv | 68 ++++++
 rtl/m72_rom_loader.sv | 197 +++++++++++++++++++
 tb/tb_m72_rom_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m72_loader_pkg.sv
// Shared constants and types for the m72 ROM loader: region geometry, widths and the FSM state encoding.
package m72_loader_pkg;

  localparam int NUM_REGIONS = 8;
  localparam int REGION_W    = $clog2(NUM_REGIONS);
  localparam int HDR_BYTES   = 2 * NUM_REGIONS;
  localparam int ADDR_W      = 25;
  localparam int WORD_W      = 23;

  localparam int         DEF_UNIT_LOG2 = 12;
  localparam logic [7:0] DEF_ROM_INDEX = 8'h00;

  typedef logic [REGION_W-1:0] region_id_t;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
    WRITE,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/m72_region_map.sv
// Cumulative region end table filled from the download header, plus a
// combinational lookup of the lowest region whose end lies above a byte offset.
module m72_region_map
  import m72_loader_pkg::*;
#(
  parameter int UNIT_LOG2 = DEF_UNIT_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              wr_en_i,
  input  region_id_t        wr_idx_i,
  input  logic [15:0]       size_i,
  input  logic [ADDR_W-1:0] offset_i,
  output logic              hit_o,
  output region_id_t        region_o,
  output logic [ADDR_W-1:0] local_o
);

  localparam int SUM_W = ADDR_W + 5;

  logic [ADDR_W-1:0] end_q   [NUM_REGIONS];
  logic [ADDR_W-1:0] start_w [NUM_REGIONS];
  logic [SUM_W-1:0]  sum;
  logic [ADDR_W-1:0] new_end;
  logic [ADDR_W-1:0] base;

  // NOTE: every variable written in a combinational block gets a default first, so no path leaves it holding a stale value (which would infer a latch).
  always_comb begin
    start_w[0] = '0;
    for (int r = 1; r < NUM_REGIONS; r++) start_w[r] = end_q[r-1];
  end

  always_comb begin
    sum     = SUM_W'(start_w[wr_idx_i]) + (SUM_W'(size_i) << UNIT_LOG2);
    new_end = (sum > SUM_W'({ADDR_W{1'b1}})) ? {ADDR_W{1'b1}} : sum[ADDR_W-1:0];
  end

  // NOTE: the end table is a handful of flops that must read as empty after reset,
  // so it is reset explicitly rather than left to be inferred as RAM.
  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGIONS; r++) end_q[r] <= '0;
    end else if (clear_i) begin
      for (int r = 0; r < NUM_REGIONS; r++) end_q[r] <= '0;
    end else if (wr_en_i) begin
      end_q[wr_idx_i] <= new_end;
    end
  end

  // Descending scan so the lowest matching region wins; zero-size regions never match
  // because their end equals the previous end.
  always_comb begin
    hit_o    = 1'b0;
    region_o = '0;
    base     = '0;
    for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
      if (offset_i < end_q[r]) begin
        hit_o    = 1'b1;
        region_o = REGION_W'(r);
        base     = start_w[r];
      end
    end
    local_o = offset_i - base;
  end

endmodule

// File: rtl/m72_rom_loader.sv
// Consumes the ioctl ROM download: parses the region-size header, packs bytes
// into 16-bit words and hands each word to the ROM memories over a req/ack handshake.
module m72_rom_loader
  import m72_loader_pkg::*;
#(
  parameter int         UNIT_LOG2 = DEF_UNIT_LOG2,
  parameter logic [7:0] ROM_INDEX = DEF_ROM_INDEX
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [REGION_W-1:0] mem_region,
  output logic [WORD_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic [1:0]        mem_be,
  output logic              load_done,
  output logic              err_overflow,
  output logic              err_proto
);

  state_t state_q, state_d;

  logic              dl_q;
  logic [7:0]        hdr_hi_q, hdr_hi_d;
  logic              latch_v_q, latch_v_d;
  logic [7:0]        latch_byte_q, latch_byte_d;
  region_id_t        latch_region_q, latch_region_d;
  logic [WORD_W-1:0] latch_word_q, latch_word_d;
  region_id_t        mem_region_q, mem_region_d;
  logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_data_q, mem_data_d;
  logic [1:0]        mem_be_q, mem_be_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_proto_q, err_proto_d;

  logic              active, dl_start, is_hdr_byte, hdr_last, hdr_wr;
  logic              map_hit, latch_match, data_odd, data_even, even_flush;
  region_id_t        map_region;
  logic [ADDR_W-1:0] offset, map_local;
  logic [WORD_W-1:0] word;
  logic              unused_bits;

  assign active      = ioctl_wr && ioctl_download && (ioctl_index == ROM_INDEX);
  assign dl_start    = ioctl_download && !dl_q && (ioctl_index == ROM_INDEX)
                       && (state_q == IDLE || state_q == DONE);
  assign is_hdr_byte = ioctl_addr < ADDR_W'(HDR_BYTES);
  assign hdr_last    = ioctl_addr == ADDR_W'(HDR_BYTES - 1);
  assign hdr_wr      = (state_q == HEADER) && active && is_hdr_byte && ioctl_addr[0];
  // Bytes addressed below the data area wrap to a huge offset and fall out as overflow.
  assign offset      = ioctl_addr - ADDR_W'(HDR_BYTES);
  assign word        = map_local[WORD_W:1];
  assign unused_bits = map_local[ADDR_W-1];
  assign latch_match = (latch_region_q == map_region) && (latch_word_q == word);
  assign data_odd    = (state_q == DATA) && active && map_hit && map_local[0];
  assign data_even   = (state_q == DATA) && active && map_hit && !map_local[0];
  assign even_flush  = data_even && latch_v_q && !latch_match;

  m72_region_map #(.UNIT_LOG2(UNIT_LOG2)) u_map (
    .clk      (clock),
    .rst_n    (reset_n),
    .clear_i  (dl_start),
    .wr_en_i  (hdr_wr),
    .wr_idx_i (ioctl_addr[REGION_W:1]),
    .size_i   ({hdr_hi_q, ioctl_dout}),
    .offset_i (offset),
    .hit_o    (map_hit),
    .region_o (map_region),
    .local_o  (map_local)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (dl_start) state_d = HEADER;
      HEADER: if (!ioctl_download) state_d = FLUSH;
              else if (active && hdr_last) state_d = DATA;
      DATA:   if (!ioctl_download) state_d = FLUSH;
              else if (data_odd || even_flush) state_d = WRITE;
      WRITE:  if (mem_ack) state_d = DATA;
      FLUSH:  state_d = latch_v_q ? WRITE : DONE;
      DONE:   if (dl_start) state_d = HEADER;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req    = (state_q == WRITE);
    ioctl_wait = (state_q == WRITE);
    load_done  = (state_q == DONE);
  end

  always_comb begin
    hdr_hi_d       = hdr_hi_q;
    latch_v_d      = latch_v_q;
    latch_byte_d   = latch_byte_q;
    latch_region_d = latch_region_q;
    latch_word_d   = latch_word_q;
    mem_region_d   = mem_region_q;
    mem_addr_d     = mem_addr_q;
    mem_data_d     = mem_data_q;
    mem_be_d       = mem_be_q;
    err_ovf_d      = err_ovf_q;
    err_proto_d    = err_proto_q;

    if (dl_start) begin
      err_ovf_d   = 1'b0;
      err_proto_d = 1'b0;
      latch_v_d   = 1'b0;
    end
    if ((state_q == HEADER) && active && is_hdr_byte && !ioctl_addr[0]) hdr_hi_d = ioctl_dout;
    if ((state_q == DATA) && active && !map_hit) err_ovf_d = 1'b1;
    if (data_odd) begin
      mem_region_d = map_region;
      mem_addr_d   = word;
      if (latch_v_q && latch_match) begin
        mem_data_d = {ioctl_dout, latch_byte_q};
        mem_be_d   = 2'b11;
        latch_v_d  = 1'b0;
      end else begin
        mem_data_d = {ioctl_dout, 8'hFF};
        mem_be_d   = 2'b10;
      end
    end
    // A new even byte displaces a stale one: the stale byte goes out as a
    // low-half write while the new byte takes its place in the latch.
    if (data_even) begin
      if (even_flush) begin
        mem_region_d = latch_region_q;
        mem_addr_d   = latch_word_q;
        mem_data_d   = {8'hFF, latch_byte_q};
        mem_be_d     = 2'b01;
      end
      latch_v_d      = 1'b1;
      latch_byte_d   = ioctl_dout;
      latch_region_d = map_region;
      latch_word_d   = word;
    end
    if ((state_q == WRITE) && active) err_proto_d = 1'b1;
    if ((state_q == FLUSH) && latch_v_q) begin
      mem_region_d = latch_region_q;
      mem_addr_d   = latch_word_q;
      mem_data_d   = {8'hFF, latch_byte_q};
      mem_be_d     = 2'b01;
      latch_v_d    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dl_q           <= 1'b0;
      hdr_hi_q       <= '0;
      latch_v_q      <= 1'b0;
      latch_byte_q   <= '0;
      latch_region_q <= '0;
      latch_word_q   <= '0;
      mem_region_q   <= '0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      mem_be_q       <= '0;
      err_ovf_q      <= 1'b0;
      err_proto_q    <= 1'b0;
    end else begin
      dl_q           <= ioctl_download;
      hdr_hi_q       <= hdr_hi_d;
      latch_v_q      <= latch_v_d;
      latch_byte_q   <= latch_byte_d;
      latch_region_q <= latch_region_d;
      latch_word_q   <= latch_word_d;
      mem_region_q   <= mem_region_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_q     <= mem_data_d;
      mem_be_q       <= mem_be_d;
      err_ovf_q      <= err_ovf_d;
      err_proto_q    <= err_proto_d;
    end
  end

  assign mem_region   = mem_region_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data     = mem_data_q;
  assign mem_be       = mem_be_q;
  assign err_overflow = err_ovf_q;
  assign err_proto    = err_proto_q;

endmodule

// File: tb/tb_m72_rom_loader.sv
// Self-checking bench for m72_rom_loader: host byte driver, delayed-ack memory
// responder with a write log, a table of partial-word vectors and directed corner cases.
module tb_m72_rom_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        mem_req;
  logic        mem_ack;
  logic [2:0]  mem_region;
  logic [22:0] mem_addr;
  logic [15:0] mem_data;
  logic [1:0]  mem_be;
  logic        load_done;
  logic        err_overflow;
  logic        err_proto;

  m72_rom_loader dut (
    .clock          (clk),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .mem_region     (mem_region),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_be         (mem_be),
    .load_done      (load_done),
    .err_overflow   (err_overflow),
    .err_proto      (err_proto)
  );

  always #5 clk = ~clk;

  typedef logic [43:0] wrec_t;
  typedef struct {
    logic [24:0] off;
    logic [7:0]  data;
    bit          has_wr;
    logic [2:0]  region;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } vec_t;

  wrec_t sb[$];
  vec_t  vecs[8];
  int    n_checks = 0;
  int    n_err    = 0;
  int    ack_delay = 0;
  int    ack_cnt   = 0;

  function automatic wrec_t wrec(input logic [2:0] r, input logic [22:0] a,
                                 input logic [15:0] d, input logic [1:0] b);
    return {r, a, d, b};
  endfunction

  function automatic logic [7:0] pat(input int o);
    return 8'((o * 7 + 3) & 255);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory side: ack after ack_delay idle request cycles, logging each accepted write.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) mem_ack = 1'b0;
      else if (mem_req) begin
        if (ack_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          ack_cnt = 0;
          sb.push_back({mem_region, mem_addr, mem_data, mem_be});
        end else ack_cnt++;
      end else ack_cnt = 0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((ioctl_wait || mem_req) && n < 300) begin step(); n++; end
    if (n >= 300) check("idle timeout", 1, 0);
  endtask

  task automatic pulse_raw(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    wait_idle();
    pulse_raw(a, d);
  endtask

  task automatic start_download(input logic [15:0] s0, input logic [15:0] s1);
    logic [15:0] s;
    ioctl_index = 8'h00; ioctl_download = 1'b1;
    step();
    for (int r = 0; r < 8; r++) begin
      s = (r == 0) ? s0 : (r == 1) ? s1 : 16'h0;
      send_byte(25'(2 * r), s[15:8]);
      send_byte(25'(2 * r + 1), s[7:0]);
    end
  endtask

  task automatic end_download();
    int n = 0;
    ioctl_download = 1'b0;
    while (!load_done && n < 100) begin step(); n++; end
    check("load_done", load_done, 1);
  endtask

  initial begin
    int base, req_seen, bad_wait, bad_stable;
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, req_seen, bad_wait, bad_stable, i;
    vecs[0] = '{25'd10,   8'hA1, 1'b0, 3'd0, 23'd0,  16'h0000, 2'b00};
    vecs[1] = '{25'd11,   8'hB2, 1'b1, 3'd0, 23'd5,  16'hB2A1, 2'b11};
    vecs[2] = '{25'd20,   8'hC3, 1'b0, 3'd0, 23'd0,  16'h0000, 2'b00};
    vecs[3] = '{25'd31,   8'hD4, 1'b1, 3'd0, 23'd15, 16'hD4FF, 2'b10};
    vecs[4] = '{25'd40,   8'hE5, 1'b1, 3'd0, 23'd10, 16'hFFC3, 2'b01};
    vecs[5] = '{25'd4097, 8'hF6, 1'b1, 3'd1, 23'd0,  16'hF6FF, 2'b10};
    vecs[6] = '{25'd4100, 8'h07, 1'b1, 3'd0, 23'd20, 16'hFFE5, 2'b01};
    vecs[7] = '{25'd4101, 8'h18, 1'b1, 3'd1, 23'd2,  16'h1807, 2'b11};

    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'h00;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    repeat (2) step();
    check("reset flags", {mem_req, ioctl_wait, load_done, err_overflow, err_proto}, 0);
    check("reset mem bus", {mem_region, mem_addr, mem_data, mem_be}, 0);
    reset_n = 1'b1;
    step();

    // Full 8 KB stream into regions 0 and 1, immediate ack.
    start_download(16'd1, 16'd1);
    check("start load_done low", load_done, 0);
    base = sb.size();
    for (int o = 0; o < 8192; o++) send_byte(25'(o + 16), pat(o));
    end_download();
    check("bulk count at done", sb.size() - base, 4096);
    for (int k = 0; k < 4096 && base + k < sb.size(); k++)
      check("bulk write", sb[base + k],
            wrec(3'(k / 2048), 23'(k % 2048), {pat(2 * k + 1), pat(2 * k)}, 2'b11));

    // Download window on another index must leave DONE untouched.
    ioctl_index = 8'h01; ioctl_download = 1'b1;
    step();
    base = sb.size();
    send_byte(25'd17, 8'h55);
    check("idx1 wait", ioctl_wait, 0);
    ioctl_download = 1'b0;
    repeat (3) step();
    check("idx1 load_done held", load_done, 1);
    check("idx1 no write", sb.size(), base);

    // Partial-word vectors.
    start_download(16'd1, 16'd1);
    check("restart clears done", load_done, 0);
    for (int v = 0; v < 8; v++) begin
      base = sb.size();
      send_byte(vecs[v].off + 25'd16, vecs[v].data);
      wait_idle();
      step();
      if (vecs[v].has_wr) begin
        check($sformatf("vec%0d count", v), sb.size(), base + 1);
        if (sb.size() > base)
          check($sformatf("vec%0d write", v), sb[base],
                wrec(vecs[v].region, vecs[v].addr, vecs[v].wdata, vecs[v].be));
      end else
        check($sformatf("vec%0d no write", v), sb.size(), base);
    end

    // Odd-length tail: last byte sits at region 1 byte 0 and is flushed.
    base = sb.size();
    send_byte(25'd4094 + 25'd16, 8'hAA);
    send_byte(25'd4095 + 25'd16, 8'hBB);
    send_byte(25'd4096 + 25'd16, 8'h5A);
    end_download();
    check("tail count", sb.size(), base + 2);
    if (sb.size() >= base + 2) begin
      check("tail word", sb[base], wrec(3'd0, 23'd2047, 16'hBBAA, 2'b11));
      check("tail flush", sb[base + 1], wrec(3'd1, 23'd0, 16'hFF5A, 2'b01));
    end

    // Byte just past the last region.
    start_download(16'd1, 16'd1);
    base = sb.size();
    req_seen = 0;
    send_byte(25'd8192 + 25'd16, 8'h77);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_req) req_seen++;
    end
    step();
    check("ovf no req", req_seen, 0);
    check("ovf flag", err_overflow, 1);
    check("ovf no write", sb.size(), base);
    end_download();
    check("ovf sticky", err_overflow, 1);

    start_download(16'd1, 16'd1);
    check("ovf cleared on start", err_overflow, 0);

    // Byte on a non-ROM index mid-download.
    base = sb.size();
    ioctl_index = 8'h01;
    pulse_raw(25'd3 + 25'd16, 8'h99);
    check("idx1 data wait", ioctl_wait, 0);
    ioctl_index = 8'h00;
    repeat (2) step();
    check("idx1 data no write", sb.size(), base);
    check("idx1 data flags", {err_overflow, err_proto}, 0);

    // Slow ack: wait must follow req, bus must hold steady.
    ack_delay = 5;
    send_byte(25'd8 + 25'd16, 8'h3C);
    send_byte(25'd9 + 25'd16, 8'hC3);
    req_seen = 0; bad_wait = 0; bad_stable = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ioctl_wait !== mem_req) bad_wait++;
      if (mem_req) begin
        req_seen++;
        if ({mem_region, mem_addr, mem_data, mem_be} !== wrec(3'd0, 23'd4, 16'hC33C, 2'b11))
          bad_stable++;
      end
    end
    step();
    check("slow req cycles", req_seen, 6);
    check("slow wait tracks req", bad_wait, 0);
    check("slow bus stable", bad_stable, 0);
    check("slow write", sb[sb.size() - 1], wrec(3'd0, 23'd4, 16'hC33C, 2'b11));

    // Host ignores wait: byte dropped, err_proto raised, latch untouched.
    base = sb.size();
    send_byte(25'd10 + 25'd16, 8'h01);
    send_byte(25'd11 + 25'd16, 8'h02);
    pulse_raw(25'd12 + 25'd16, 8'hEE);
    check("proto flag", err_proto, 1);
    wait_idle();
    check("proto count", sb.size(), base + 1);
    check("proto write", sb[sb.size() - 1], wrec(3'd0, 23'd5, 16'h0201, 2'b11));
    send_byte(25'd13 + 25'd16, 8'h44);
    wait_idle();
    check("proto dropped byte", sb[sb.size() - 1], wrec(3'd0, 23'd6, 16'h44FF, 2'b10));

    // Asynchronous reset while a request is pending.
    ack_delay = 50;
    send_byte(25'd14 + 25'd16, 8'h61);
    send_byte(25'd15 + 25'd16, 8'h62);
    repeat (2) step();
    check("pre-reset req", mem_req, 1);
    base = sb.size();
    @(negedge clk); #2;
    reset_n = 1'b0; ioctl_download = 1'b0;
    #1;
    check("async req drop", {mem_req, ioctl_wait}, 0);
    check("async flags", {load_done, err_overflow, err_proto}, 0);
    check("async be", mem_be, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    ack_delay = 0;
    repeat (3) step();
    check("aborted write", sb.size(), base);
    start_download(16'd1, 16'd1);
    send_byte(25'd16, 8'h11);
    send_byte(25'd17, 8'h22);
    wait_idle();
    check("post-reset count", sb.size(), base + 1);
    check("post-reset write", sb[sb.size() - 1], wrec(3'd0, 23'd0, 16'h2211, 2'b11));
    end_download();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
